// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle for fetch_queue.
// Master drives fetch/redirect/ID-ready; slave is the queue.
interface fetch_queue_if #(
  parameter int ADDR_W = 2
);
  logic              fetch_en;
  logic [31:0]       pc;
  logic [31:0]       inst;
  logic              flush;
  logic              fq_stop;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic [ADDR_W:0]   fq_count;

  modport master (
    output fetch_en, pc, inst, flush, id_ready,
    input  fq_stop, id_valid, id_pc, id_inst, fq_count
  );

  modport slave (
    input  fetch_en, pc, inst, flush, id_ready,
    output fq_stop, id_valid, id_pc, id_inst, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PC/IROM and ID.
// Define FQ_BYPASS_EN for same-cycle pass-through when empty.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        fq_clk,
  input  logic        fq_rst,
  fetch_queue_if.slave bus
);
  localparam logic [ADDR_W:0] W_FULL = (ADDR_W+1)'(DEPTH);

  logic [31:0]       r_pc   [DEPTH];
  logic [31:0]       r_inst [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_fetch;
  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_valid;
  logic w_pop;
  logic w_accept;
  logic w_rd;
  logic w_wr;

  assign w_fetch = bus.fetch_en & ~bus.flush;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == W_FULL);

`ifdef FQ_BYPASS_EN
  assign w_byp = w_empty & w_fetch & ~fq_rst;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid  = ~fq_rst & (~w_empty | w_byp);
  assign w_pop    = w_valid & bus.id_ready;
  assign w_accept = w_fetch & (~w_full | w_pop);
  // A bypassed fetch consumed this cycle never touches storage.
  assign w_rd = w_pop & ~w_empty;
  assign w_wr = w_accept & ~(w_byp & bus.id_ready) & ~fq_rst;

  assign bus.fq_stop  = ~fq_rst & w_fetch & ~w_accept;
  assign bus.id_valid = w_valid;
  assign bus.fq_count = r_count;

  always_comb begin
    bus.id_pc   = '0;
    bus.id_inst = '0;
    unique case (1'b1)
      w_byp: begin
        bus.id_pc   = bus.pc;
        bus.id_inst = bus.inst;
      end
      w_valid: begin
        bus.id_pc   = r_pc[r_rd_ptr];
        bus.id_inst = r_inst[r_rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge fq_clk) begin
    if (w_wr) begin
      r_pc[r_wr_ptr]   <= bus.pc;
      r_inst[r_wr_ptr] <= bus.inst;
    end
  end

  always_ff @(posedge fq_clk) begin
    if (fq_rst || bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      unique case (1'b1)
        (w_wr & ~w_rd): r_count <= r_count + (ADDR_W+1)'(1);
        (w_rd & ~w_wr): r_count <= r_count - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end
endmodule
